// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the ALU issue stage: 4-bit ALU control
//               encodings, 2-bit ALUOp classes and the width of the buffered
//               payload {illegal, alu_control, rd, b, a}.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU control encodings seen on the alu_control port
    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_SRA  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;

    // ALUOp classes produced by the main decoder
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    // Width of the {illegal, alu_control} control field
    localparam int c_CTRL_W = 5;

    // Width of the full buffered bundle {illegal, alu_control, rd, b, a}
    function automatic int payload_w(input int xlen, input int rdw);
        return c_CTRL_W + rdw + 2 * xlen;
    endfunction

    // Payload width for the default 64-bit / 5-bit-index configuration
    localparam int c_PAYLOAD_W = c_CTRL_W + 5 + 2 * 64;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Combinational ALU control decoder.
//               aluop[1:0], funct3[2:0], funct7b5 -> alu_control[3:0], illegal
//               Illegal encodings report ADD so downstream sees a benign op.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        unique case (aluop)
            ALUOP_MEM: begin
                alu_control = ALU_ADD;
            end
            ALUOP_BRANCH: begin
                // Branches only need compare ops; pairs of funct3 share one
                unique case (funct3[2:1])
                    2'b00:   alu_control = ALU_SUB;
                    2'b10:   alu_control = ALU_SLT;
                    2'b11:   alu_control = ALU_SLTU;
                    default: illegal     = 1'b1;
                endcase
            end
            default: begin
                // R-type and I-type share the table; only R-type uses b5 to
                // select SUB, since for I-type bit 30 is part of the immediate.
                unique case (funct3)
                    3'b000: alu_control = (funct7b5 && (aluop == ALUOP_RTYPE))
                                          ? ALU_SUB : ALU_ADD;
                    3'b001: alu_control = ALU_SLL;
                    3'b010: alu_control = ALU_SLT;
                    3'b011: alu_control = ALU_SLTU;
                    3'b100: alu_control = ALU_XOR;
                    3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
                if (funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
                    illegal = 1'b1;
                end
            end
        endcase
        if (illegal) begin
            alu_control = ALU_ADD;
        end
    end

endmodule : alu_ctrl_decode
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : ID->EX issue stage. Decodes the ALU control for each op and
//               buffers {illegal, alu_control, rd, b, a} in a 1-entry output
//               register backed by a 1-entry skid register (valid/ready).
// Ports       : clk, reset (sync, active high), flush (sync squash)
//               in_valid/in_ready, in_aluop, in_funct3, in_funct7b5,
//               in_a, in_b, in_rd                       - upstream side
//               out_valid/out_ready, alu_control, op_a, op_b, rd, illegal
//                                                       - EX side
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RDW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_aluop,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [RDW-1:0]  in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [RDW-1:0]  rd,
    output logic            illegal
);

    localparam int c_PW = payload_w(XLEN, RDW);

    // Buffer state is {out_valid, skid_valid}; 2'b01 is unreachable
    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_FULL1 = 2'b10;
    localparam logic [1:0] S_FULL2 = 2'b11;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_PW-1:0] r_out_data;
    logic [c_PW-1:0] r_skid_data;
    logic [c_PW-1:0] w_in_data;
    logic [3:0]      w_ctrl;
    logic            w_illegal;
    logic            w_accept;
    logic            w_present;
    logic            w_load_out_in;
    logic            w_load_out_skid;
    logic            w_load_skid;

    alu_ctrl_decode u_decode (
        .aluop       (in_aluop),
        .funct3      (in_funct3),
        .funct7b5    (in_funct7b5),
        .alu_control (w_ctrl),
        .illegal     (w_illegal)
    );

    assign w_in_data = {w_illegal, w_ctrl, in_rd, in_b, in_a};

    // Flush squashes both the incoming op and any transfer this cycle
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_present = out_valid && out_ready && !flush;

    assign w_load_out_in   = w_accept && ((r_state == S_EMPTY) ||
                                          ((r_state == S_FULL1) && w_present));
    assign w_load_skid     = w_accept && (r_state == S_FULL1) && !w_present;
    assign w_load_out_skid = w_present && (r_state == S_FULL2);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_EMPTY: begin
                if (w_accept) w_state_nxt = S_FULL1;
            end
            S_FULL1: begin
                if (w_accept && !w_present)      w_state_nxt = S_FULL2;
                else if (!w_accept && w_present) w_state_nxt = S_EMPTY;
            end
            S_FULL2: begin
                if (w_present) w_state_nxt = S_FULL1;
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end
    end

    // Output logic
    always_comb begin
        out_valid = r_state[1];
        in_ready  = !r_state[0];
    end

    // Payload registers; stale data after flush is qualified by out_valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_out_in) begin
                r_out_data <= w_in_data;
            end else if (w_load_out_skid) begin
                r_out_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= w_in_data;
            end
        end
    end

    assign {illegal, alu_control, rd, op_b, op_a} = r_out_data;

endmodule : alu_issue_stage
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Self-checking bench for alu_issue_stage. A depth-2 FIFO model
//               (queue) plus a table-driven decode reference predict every
//               output; directed steps are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    localparam int XLEN = 64;
    localparam int RDW  = 5;
    localparam int c_PW = 5 + RDW + 2 * XLEN;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_aluop;
    logic [2:0]      in_funct3;
    logic            in_funct7b5;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [RDW-1:0]  in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [RDW-1:0]  rd;
    logic            illegal;

    int n_checks = 0;
    int n_pass   = 0;

    logic [c_PW-1:0] q_model[$];

    alu_issue_stage #(.XLEN(XLEN), .RDW(RDW)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_aluop    (in_aluop),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .rd          (rd),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Reference decode: returns {illegal, alu_control}
    function automatic logic [4:0] ref_decode(input logic [1:0] aluop,
                                              input logic [2:0] f3,
                                              input logic       b5);
        logic [31:0] tab;
        logic [3:0]  ctl;
        logic        ill;
        tab = {4'd0, 4'd1, 4'd4, 4'd9, 4'd7, 4'd8, 4'd3, 4'd2};
        ill = 1'b0;
        ctl = 4'd2;
        if (aluop == 2'd1) begin
            if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
            else if (f3 < 3'd2)           ctl = 4'd6;
            else if (f3 < 3'd6)           ctl = 4'd8;
            else                          ctl = 4'd7;
        end else if (aluop >= 2'd2) begin
            ctl = tab[f3*4 +: 4];
            if (b5) begin
                if (f3 == 3'd0)      ctl = (aluop == 2'd2) ? 4'd6 : 4'd2;
                else if (f3 == 3'd5) ctl = 4'd5;
                else                 ill = 1'b1;
            end
        end
        if (ill) ctl = 4'd2;
        return {ill, ctl};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: model the transfer, then compare after the edge settles
    task automatic step(input string tag);
        logic acc;
        logic pres;
        logic [c_PW-1:0] item;
        acc  = in_valid && (q_model.size() < 2);
        pres = out_ready && (q_model.size() > 0);
        item = {ref_decode(in_aluop, in_funct3, in_funct7b5), in_rd, in_b, in_a};
        @(posedge clk);
        #1;
        if (reset || flush) begin
            q_model.delete();
        end else begin
            if (pres) void'(q_model.pop_front());
            if (acc)  q_model.push_back(item);
        end
        chk({tag, ".out_valid"}, 256'(out_valid), 256'(q_model.size() > 0));
        chk({tag, ".in_ready"},  256'(in_ready),  256'(q_model.size() < 2));
        if (q_model.size() > 0) begin
            chk({tag, ".payload"},
                256'({illegal, alu_control, rd, op_b, op_a}), 256'(q_model[0]));
        end
    endtask

    task automatic set_op(input logic [1:0] aluop, input logic [2:0] f3,
                          input logic b5, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [RDW-1:0] r);
        in_valid    = 1'b1;
        in_aluop    = aluop;
        in_funct3   = f3;
        in_funct7b5 = b5;
        in_a        = a;
        in_b        = b;
        in_rd       = r;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".zero"}, 256'({illegal, alu_control, rd, op_b, op_a}), 256'(0));
    endtask

    initial begin
        logic [3:0] sweep_exp [8];
        sweep_exp = '{4'd2, 4'd3, 4'd8, 4'd7, 4'd9, 4'd4, 4'd1, 4'd0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_aluop = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
        in_a = '0; in_b = '0; in_rd = '0;

        // Reset held two cycles; an offered input is dropped
        set_op(2'd2, 3'd0, 1'b0, 64'd7, 64'd8, 5'd4);
        step("rst0"); chk_zero("rst0");
        step("rst1"); chk_zero("rst1");
        in_valid = 1'b0;
        reset = 1'b0;
        step("idle"); chk_zero("idle");

        // SUB then ADD with out_ready high
        out_ready = 1'b1;
        set_op(2'd2, 3'd0, 1'b1, 64'd13, 64'd3, 5'd1);
        step("sub");
        chk("sub.ctl", 256'(alu_control), 256'(6));
        chk("sub.a",   256'(op_a), 256'(13));
        chk("sub.b",   256'(op_b), 256'(3));
        set_op(2'd2, 3'd0, 1'b0, 64'd13, 64'd3, 5'd2);
        step("add");
        chk("add.ctl", 256'(alu_control), 256'(2));

        // R-type funct3 sweep at one op per cycle
        for (int f = 0; f < 8; f++) begin
            set_op(2'd2, 3'(f), 1'b0, 64'(f * 11), 64'(~f), 5'(f));
            step("sweep");
            chk("sweep.ctl", 256'(alu_control), 256'(sweep_exp[f]));
        end
        set_op(2'd3, 3'd5, 1'b1, 64'hFFFF_0000_1234_5678, 64'd5, 5'd10);
        step("srai");
        chk("srai.ctl", 256'(alu_control), 256'(5));
        set_op(2'd3, 3'd0, 1'b1, 64'd1, 64'd2, 5'd11);
        step("addi");
        chk("addi.ctl", 256'(alu_control), 256'(2));
        chk("addi.ill", 256'(illegal), 256'(0));

        // Illegal encodings still flow downstream as ADD
        set_op(2'd1, 3'd2, 1'b0, 64'd3, 64'd4, 5'd12);
        step("ill_br");
        chk("ill_br.ill", 256'(illegal), 256'(1));
        chk("ill_br.ctl", 256'(alu_control), 256'(2));
        set_op(2'd2, 3'd1, 1'b1, 64'd3, 64'd4, 5'd13);
        step("ill_r");
        chk("ill_r.ill", 256'(illegal), 256'(1));
        in_valid = 1'b0;
        step("drain");

        // Stall: rd=1,2 fill the buffer, rd=3 is held back
        out_ready = 1'b0;
        set_op(2'd0, 3'd0, 1'b0, 64'd100, 64'd200, 5'd1);
        step("stall1");
        set_op(2'd0, 3'd0, 1'b0, 64'd101, 64'd201, 5'd2);
        step("stall2");
        chk("stall2.in_ready", 256'(in_ready), 256'(0));
        set_op(2'd0, 3'd0, 1'b0, 64'd102, 64'd202, 5'd3);
        step("stall3");
        chk("stall3.rd", 256'(rd), 256'(1));
        out_ready = 1'b1;
        step("rel1"); chk("rel1.rd", 256'(rd), 256'(2));
        step("rel2"); chk("rel2.rd", 256'(rd), 256'(3));
        in_valid = 1'b0;
        step("rel3");
        chk("rel3.out_valid", 256'(out_valid), 256'(0));

        // Flush while FULL2 with rd=9 offered
        out_ready = 1'b0;
        set_op(2'd2, 3'd4, 1'b0, 64'd5, 64'd6, 5'd7);
        step("fl_fill1");
        set_op(2'd2, 3'd6, 1'b0, 64'd5, 64'd6, 5'd8);
        step("fl_fill2");
        set_op(2'd2, 3'd7, 1'b0, 64'd5, 64'd6, 5'd9);
        flush = 1'b1;
        step("flush");
        chk("flush.out_valid", 256'(out_valid), 256'(0));
        chk("flush.in_ready",  256'(in_ready),  256'(1));
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step("post_flush0");
        step("post_flush1");

        // Reset mid-stream
        set_op(2'd2, 3'd2, 1'b0, 64'd9, 64'd9, 5'd14);
        step("mid0");
        reset = 1'b1;
        step("mid_rst");
        chk_zero("mid_rst");
        reset = 1'b0; in_valid = 1'b0;
        step("mid_after");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_op(2'($urandom), 3'($urandom), 1'($urandom),
                   {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            reset     = ($urandom_range(0, 79) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_issue_stage
`default_nettype wire
